// File: rtl/eco32f_pkg.sv
// Shared types for the eco32f load/store unit: FSM states, access sizes
// and big-endian byte-lane select constants.
package eco32f_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    localparam logic [3:0] BSEL_WORD  = 4'b1111;
    localparam logic [3:0] BSEL_HALF0 = 4'b1100;
    localparam logic [3:0] BSEL_HALF1 = 4'b0011;
    localparam logic [3:0] BSEL_BYTE0 = 4'b1000;

endpackage

// File: rtl/eco32f_lsu_align.sv
// Combinational lane logic: store replication, big-endian byte selects,
// load lane extraction with sign/zero extension, misalignment detect.
module eco32f_lsu_align
    import eco32f_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  adr,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  bsel,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    assign half = adr[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        byte_v = rdata[31:24];
        unique case (adr)
            2'b00: byte_v = rdata[31:24];
            2'b01: byte_v = rdata[23:16];
            2'b10: byte_v = rdata[15:8];
            2'b11: byte_v = rdata[7:0];
        endcase
    end

    always_comb begin
        bsel     = BSEL_WORD;
        wdata    = sdata;
        ldata    = rdata;
        misalign = |adr;
        case (size)
            SZ_HALF: begin
                bsel     = adr[1] ? BSEL_HALF1 : BSEL_HALF0;
                wdata    = {2{sdata[15:0]}};
                ldata    = {{16{sign & half[15]}}, half};
                misalign = adr[0];
            end
            SZ_BYTE: begin
                bsel     = BSEL_BYTE0 >> adr;
                wdata    = {4{sdata[7:0]}};
                ldata    = {{24{sign & byte_v[7]}}, byte_v};
                misalign = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/eco32f_lsu.sv
// MEM-stage load/store unit. Optional bus-error termination is enabled
// by defining ECO32F_LSU_BUSERR_EN.
module eco32f_lsu
    import eco32f_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_stall,
    input  logic        mem_stall,
    input  logic        ex_flush,
    input  logic        mem_flush,
    input  logic        ex_op_lw,
    input  logic        ex_op_lh,
    input  logic        ex_op_lhu,
    input  logic        ex_op_lb,
    input  logic        ex_op_lbu,
    input  logic        ex_op_sw,
    input  logic        ex_op_sh,
    input  logic        ex_op_sb,
    input  logic [31:0] ex_add_result,
    input  logic [31:0] ex_rf_y,
    output logic        lsu_stall,
    output logic        mem_except_align,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_adr,
    output logic [3:0]  dbus_bsel,
    output logic [31:0] dbus_dat_o,
    input  logic [31:0] dbus_dat_i,
    input  logic        dbus_ack,
    output logic        wb_op_load,
    output logic [31:0] wb_lsu_result
`ifdef ECO32F_LSU_BUSERR_EN
    ,
    input  logic        dbus_err,
    output logic        mem_except_buserr
`endif
);

    lsu_state_t  state;
    logic        op_lw, op_lh, op_lhu, op_lb, op_lbu;
    logic        op_sw, op_sh, op_sb;
    logic [31:0] adr;
    logic [31:0] sdata;
    logic [31:0] lat;
    logic        killed;

    logic        is_load, is_store, any_op;
    logic [1:0]  size;
    logic        sign;
    logic        misalign;
    logic [31:0] ldata;
    logic        issue, busy, term, err_now;

    always_ff @(posedge clk) begin
        if (!rst) begin
            {op_lw, op_lh, op_lhu, op_lb, op_lbu} <= 5'd0;
            {op_sw, op_sh, op_sb} <= 3'd0;
            adr   <= 32'd0;
            sdata <= 32'd0;
        end else if (!ex_stall) begin
            if (ex_flush) begin
                {op_lw, op_lh, op_lhu, op_lb, op_lbu} <= 5'd0;
                {op_sw, op_sh, op_sb} <= 3'd0;
            end else begin
                {op_lw, op_lh, op_lhu, op_lb, op_lbu} <=
                    {ex_op_lw, ex_op_lh, ex_op_lhu, ex_op_lb, ex_op_lbu};
                {op_sw, op_sh, op_sb} <= {ex_op_sw, ex_op_sh, ex_op_sb};
            end
            adr   <= ex_add_result;
            sdata <= ex_rf_y;
        end
    end

    assign is_load  = op_lw | op_lh | op_lhu | op_lb | op_lbu;
    assign is_store = op_sw | op_sh | op_sb;
    assign any_op   = is_load | is_store;
    assign sign     = op_lh | op_lb;

    always_comb begin
        size = SZ_BYTE;
        unique case (1'b1)
            op_lw | op_sw:          size = SZ_WORD;
            op_lh | op_lhu | op_sh: size = SZ_HALF;
            default:                size = SZ_BYTE;
        endcase
    end

    eco32f_lsu_align u_align (
        .size     (size),
        .sign     (sign),
        .adr      (adr[1:0]),
        .sdata    (sdata),
        .rdata    (dbus_dat_i),
        .bsel     (dbus_bsel),
        .wdata    (dbus_dat_o),
        .ldata    (ldata),
        .misalign (misalign)
    );

`ifdef ECO32F_LSU_BUSERR_EN
    assign term              = dbus_ack | dbus_err;
    assign err_now           = busy & dbus_err;
    assign mem_except_buserr = err_now;
`else
    assign term    = dbus_ack;
    assign err_now = 1'b0;
`endif

    // killed: instruction flushed while it still sits in MEM
    assign issue = (state == ST_IDLE) & any_op & !misalign
                 & !mem_flush & !killed;
    assign busy  = issue | (state == ST_ACCESS);

    assign dbus_req         = rst & busy;
    assign dbus_we          = is_store;
    assign dbus_adr         = {adr[31:2], 2'b00};
    assign lsu_stall        = busy & !term;
    assign mem_except_align = any_op & misalign & !mem_flush & !killed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            lat    <= 32'd0;
            killed <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (issue) begin
                        if (!term)          state <= ST_ACCESS;
                        else if (mem_stall) state <= ST_HOLD;
                    end
                end
                ST_ACCESS: begin
                    if (term) state <= mem_stall ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (!mem_stall) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (busy & term) lat <= ldata;
            if (!mem_stall)                killed <= 1'b0;
            else if (mem_flush | err_now)  killed <= 1'b1;
        end
    end

    // Zero-wait completion forwards bus data straight into WB
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_op_load    <= 1'b0;
            wb_lsu_result <= 32'd0;
        end else if (!mem_stall) begin
            wb_op_load    <= is_load & !misalign & !mem_flush
                           & !killed & !err_now;
            wb_lsu_result <= (busy & term) ? ldata : lat;
        end
    end

endmodule

// File: tb/tb_eco32f_lsu.sv
// Self-checking bench for eco32f_lsu: directed steps plus random
// accesses checked against a behavioural lane/extension model.
module tb_eco32f_lsu;

    localparam int LW = 0, LH = 1, LHU = 2, LB = 3;
    localparam int LBU = 4, SW = 5, SH = 6, SB = 7;

    logic        clk = 1'b0;
    logic        rst;
    int          cur_op;
    logic        ex_stall, mem_stall, xstall;
    logic        ex_flush, mem_flush;
    logic        ex_op_lw, ex_op_lh, ex_op_lhu, ex_op_lb, ex_op_lbu;
    logic        ex_op_sw, ex_op_sh, ex_op_sb;
    logic [31:0] ex_add_result, ex_rf_y;
    logic        lsu_stall, mem_except_align;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_adr, dbus_dat_o, dbus_dat_i;
    logic [3:0]  dbus_bsel;
    logic        dbus_ack;
    logic        wb_op_load;
    logic [31:0] wb_lsu_result;
`ifdef ECO32F_LSU_BUSERR_EN
    logic        dbus_err;
    logic        mem_except_buserr;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_stall = lsu_stall | xstall;
    assign ex_stall  = mem_stall;
    assign ex_op_lw  = (cur_op == LW);
    assign ex_op_lh  = (cur_op == LH);
    assign ex_op_lhu = (cur_op == LHU);
    assign ex_op_lb  = (cur_op == LB);
    assign ex_op_lbu = (cur_op == LBU);
    assign ex_op_sw  = (cur_op == SW);
    assign ex_op_sh  = (cur_op == SH);
    assign ex_op_sb  = (cur_op == SB);

    eco32f_lsu dut (
        .clk              (clk),
        .rst              (rst),
        .ex_stall         (ex_stall),
        .mem_stall        (mem_stall),
        .ex_flush         (ex_flush),
        .mem_flush        (mem_flush),
        .ex_op_lw         (ex_op_lw),
        .ex_op_lh         (ex_op_lh),
        .ex_op_lhu        (ex_op_lhu),
        .ex_op_lb         (ex_op_lb),
        .ex_op_lbu        (ex_op_lbu),
        .ex_op_sw         (ex_op_sw),
        .ex_op_sh         (ex_op_sh),
        .ex_op_sb         (ex_op_sb),
        .ex_add_result    (ex_add_result),
        .ex_rf_y          (ex_rf_y),
        .lsu_stall        (lsu_stall),
        .mem_except_align (mem_except_align),
        .dbus_req         (dbus_req),
        .dbus_we          (dbus_we),
        .dbus_adr         (dbus_adr),
        .dbus_bsel        (dbus_bsel),
        .dbus_dat_o       (dbus_dat_o),
        .dbus_dat_i       (dbus_dat_i),
        .dbus_ack         (dbus_ack),
        .wb_op_load       (wb_op_load),
        .wb_lsu_result    (wb_lsu_result)
`ifdef ECO32F_LSU_BUSERR_EN
        ,
        .dbus_err         (dbus_err),
        .mem_except_buserr(mem_except_buserr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_ld(input int op);
        return op <= LBU;
    endfunction

    function automatic bit mis(input int op, input logic [31:0] a);
        if (op == LW || op == SW) return (a % 4) != 0;
        if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_bsel(input int op,
                                             input logic [31:0] a);
        int k;
        k = int'(a % 4);
        if (op == LW || op == SW) return 32'd15;
        if (op == LH || op == LHU || op == SH) return (k >= 2) ? 32'd3 : 32'd12;
        return 32'd1 << (3 - k);
    endfunction

    function automatic logic [31:0] ref_wdat(input int op,
                                             input logic [31:0] y);
        if (op == SB) return (y & 32'hFF) * 32'h01010101;
        if (op == SH) return (y & 32'hFFFF) * 32'h00010001;
        return y;
    endfunction

    function automatic logic [31:0] ref_load(input int op,
                                             input logic [31:0] a,
                                             input logic [31:0] d);
        logic [31:0] v;
        int k;
        k = int'(a % 4);
        if (op == LW) return d;
        if (op == LH || op == LHU) begin
            v = (k >= 2) ? (d & 32'hFFFF) : (d >> 16);
            if (op == LH && v >= 32'h8000) v = v | 32'hFFFF0000;
            return v;
        end
        v = (d >> (8 * (3 - k))) & 32'hFF;
        if (op == LB && v >= 32'h80) v = v | 32'hFFFFFF00;
        return v;
    endfunction

    // One instruction through MEM: ack after wt cycles, external stall
    // held for hold cycles starting at the ack cycle.
    task automatic run(input int op, input logic [31:0] a,
                       input logic [31:0] y, input logic [31:0] d,
                       input int wt, input int hold);
        @(negedge clk);
        cur_op = op;
        ex_add_result = a;
        ex_rf_y = y;
        dbus_ack = 1'b0;
        xstall = 1'b0;
        @(posedge clk);
        #1;
        cur_op = -1;
        ex_add_result = $urandom;
        ex_rf_y = $urandom;
        if (mis(op, a)) begin
            @(negedge clk);
            chk("align_exc", mem_except_align, 1);
            chk("align_noreq", dbus_req, 0);
            chk("align_nostall", lsu_stall, 0);
            @(posedge clk);
            #1;
            chk("align_wb", wb_op_load, 0);
            return;
        end
        for (int c = 0; c <= wt; c++) begin
            dbus_ack = (c == wt);
            dbus_dat_i = (c == wt) ? d : $urandom;
            xstall = (c == wt) && (hold > 0);
            @(negedge clk);
            chk("req", dbus_req, 1);
            chk("adr", dbus_adr, a & 32'hFFFFFFFC);
            chk("we", dbus_we, !is_ld(op));
            chk("bsel", dbus_bsel, ref_bsel(op, a));
            if (!is_ld(op)) chk("dat_o", dbus_dat_o, ref_wdat(op, y));
            chk("stall", lsu_stall, c != wt);
            chk("align_ok", mem_except_align, 0);
            @(posedge clk);
            #1;
        end
        dbus_ack = 1'b0;
        dbus_dat_i = $urandom;
        for (int h = 1; h <= hold; h++) begin
            xstall = (h < hold);
            @(negedge clk);
            chk("no_reissue", dbus_req, 0);
            @(posedge clk);
            #1;
        end
        xstall = 1'b0;
        chk("wb_op", wb_op_load, is_ld(op));
        if (is_ld(op)) chk("wb_res", wb_lsu_result, ref_load(op, a, d));
    endtask

    initial begin
        rst = 1'b0;
        cur_op = -1;
        ex_flush = 1'b0;
        mem_flush = 1'b0;
        ex_add_result = 32'd0;
        ex_rf_y = 32'd0;
        dbus_dat_i = 32'd0;
        dbus_ack = 1'b0;
        xstall = 1'b0;
`ifdef ECO32F_LSU_BUSERR_EN
        dbus_err = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dbus_req, 0);
        chk("rst_wbop", wb_op_load, 0);
        chk("rst_wbres", wb_lsu_result, 0);
        chk("rst_align", mem_except_align, 0);
        chk("rst_stall", lsu_stall, 0);
        rst = 1'b1;

        run(LB, 32'h1003, 32'h0, 32'h112233F0, 0, 0);
        run(SH, 32'h2002, 32'hDEADBEEF, 32'h0, 3, 0);
        run(LW, 32'h3001, 32'h0, 32'h0, 0, 0);
        run(LHU, 32'h4000, 32'h0, 32'h8001A5A5, 0, 5);
        run(SB, 32'h2001, 32'h12345678, 32'h0, 1, 0);
        run(LH, 32'h4002, 32'h0, 32'h1234F00F, 2, 1);
        run(LBU, 32'h1001, 32'h0, 32'h11C23344, 0, 0);

        // mem_flush one cycle after issue: access runs to ack, result dropped
        @(negedge clk);
        cur_op = LW;
        ex_add_result = 32'h5000;
        @(posedge clk);
        #1;
        cur_op = -1;
        @(negedge clk);
        chk("fl_req0", dbus_req, 1);
        @(posedge clk);
        #1;
        mem_flush = 1'b1;
        @(negedge clk);
        chk("fl_req1", dbus_req, 1);
        chk("fl_stall1", lsu_stall, 1);
        @(posedge clk);
        #1;
        mem_flush = 1'b0;
        dbus_ack = 1'b1;
        dbus_dat_i = 32'h55AA55AA;
        @(negedge clk);
        chk("fl_req2", dbus_req, 1);
        chk("fl_stall2", lsu_stall, 0);
        @(posedge clk);
        #1;
        dbus_ack = 1'b0;
        chk("fl_wb", wb_op_load, 0);

        // store with mem_flush is never issued
        @(negedge clk);
        cur_op = SW;
        ex_add_result = 32'h6000;
        @(posedge clk);
        #1;
        cur_op = -1;
        mem_flush = 1'b1;
        @(negedge clk);
        chk("sfl_req", dbus_req, 0);
        @(posedge clk);
        #1;
        mem_flush = 1'b0;
        @(negedge clk);
        chk("sfl_req_after", dbus_req, 0);

        // ex_flush kills the instruction entering MEM
        cur_op = LW;
        ex_add_result = 32'h6100;
        ex_flush = 1'b1;
        @(posedge clk);
        #1;
        cur_op = -1;
        ex_flush = 1'b0;
        @(negedge clk);
        chk("exfl_req", dbus_req, 0);

        // reset in the middle of an access
        run(LW, 32'h100, 32'h0, 32'hCAFEF00D, 0, 0);
        @(negedge clk);
        cur_op = LW;
        ex_add_result = 32'h7000;
        @(posedge clk);
        #1;
        cur_op = -1;
        @(posedge clk);
        #1;
        chk("rs_req_pre", dbus_req, 1);
        chk("rs_res_pre", wb_lsu_result, 32'hCAFEF00D);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rs_req", dbus_req, 0);
        chk("rs_stall", lsu_stall, 0);
        chk("rs_wbop", wb_op_load, 0);
        chk("rs_wbres", wb_lsu_result, 0);
        chk("rs_align", mem_except_align, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rs_idle", dbus_req, 0);

`ifdef ECO32F_LSU_BUSERR_EN
        @(negedge clk);
        cur_op = LW;
        ex_add_result = 32'h8000;
        @(posedge clk);
        #1;
        cur_op = -1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("be_quiet", mem_except_buserr, 0);
            chk("be_stall", lsu_stall, 1);
            @(posedge clk);
            #1;
        end
        dbus_err = 1'b1;
        @(negedge clk);
        chk("be_pulse", mem_except_buserr, 1);
        chk("be_release", lsu_stall, 0);
        @(posedge clk);
        #1;
        dbus_err = 1'b0;
        chk("be_wb", wb_op_load, 0);
        @(negedge clk);
        chk("be_done", mem_except_buserr, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 7);
            a = $urandom;
            if ($urandom_range(0, 3) != 0 && (op == LW || op == SW))
                a = a & 32'hFFFFFFFC;
            run(op, a, $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
